// File: rtl/muxn_pkg.sv
// -----------------------------------------------------------------------------
// muxn_pkg
// Shared constants and helpers for the muxn_scan channel multiplexer.
//   MUXN_DEF_N     : default number of input channels
//   MUXN_DEF_WIDTH : default bits per channel
//   clog2()        : ceiling log2, used to size channel-index fields
// -----------------------------------------------------------------------------
package muxn_pkg;

    localparam int MUXN_DEF_N     = 7;
    localparam int MUXN_DEF_WIDTH = 1;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_scan_cnt.sv
// -----------------------------------------------------------------------------
// muxn_scan_cnt
// Modulo-N channel counter used by the auto-scan mode of muxn_scan.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   inc   : advance one channel, wrapping N-1 -> 0
//   clr   : synchronous clear; when inc is also high the count lands on 1,
//           because the current transfer already consumed channel 0
//   cnt   : current channel index
// -----------------------------------------------------------------------------
module muxn_scan_cnt
    import muxn_pkg::*;
#(
    parameter  int N     = MUXN_DEF_N,
    localparam int SEL_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] cnt
);

    logic [SEL_W-1:0] r_cnt;

    // Channel counter: clear has priority over increment and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? SEL_W'(1) : SEL_W'(0);
        end else if (inc) begin
            r_cnt <= (r_cnt == SEL_W'(N - 1)) ? SEL_W'(0) : r_cnt + SEL_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/muxn_scan.sv
// -----------------------------------------------------------------------------
// muxn_scan
// N-to-1, WIDTH-bit multiplexer with a registered output stage, valid/ready
// handshake and an auto-scan mode that steps through channels 0..N-1, one per
// accepted transfer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : request a transfer this cycle
//   mode       : 0 = channel from sel, 1 = channel from scan counter
//   sel        : external channel index (mode = 0)
//   scan_clr   : synchronous clear of the scan counter; also forces channel 0
//   din        : channel k at din[k*WIDTH +: WIDTH]
//   out_ready  : downstream accepts z this cycle
//   z, z_ch    : registered data and the channel that produced it
//   z_valid    : z / z_ch hold a transfer
//   sel_err    : (SEL_ERR_EN only) transfer used an out-of-range sel
// Optional feature macro: SEL_ERR_EN adds the sel_err output.
// -----------------------------------------------------------------------------
module muxn_scan
    import muxn_pkg::*;
#(
    parameter  int N     = MUXN_DEF_N,
    parameter  int WIDTH = MUXN_DEF_WIDTH,
    localparam int SEL_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               scan_clr,
    input  logic [N*WIDTH-1:0] din,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   z,
    output logic               z_valid,
`ifdef SEL_ERR_EN
    output logic               sel_err,
`endif
    output logic [SEL_W-1:0]   z_ch
);

    localparam int SLOTS = 2 ** SEL_W;

    logic [WIDTH-1:0] w_chan [SLOTS];
    logic [SEL_W-1:0] w_ch;
    logic [SEL_W-1:0] w_scan_cnt;
    logic             w_accept;

    logic [WIDTH-1:0] r_z;
    logic [SEL_W-1:0] r_z_ch;
    logic             r_z_valid;

    // Unused index slots (sel >= N) read as zero, so out-of-range selects
    // produce z = 0 without any extra compare on the data path.
    for (genvar k = 0; k < SLOTS; k++) begin : g_chan
        if (k < N) begin : g_live
            assign w_chan[k] = din[k*WIDTH +: WIDTH];
        end else begin : g_hole
            assign w_chan[k] = '0;
        end
    end

    // Effective channel: scan_clr forces 0, else sel or the scan counter.
    always_comb begin
        w_ch = '0;
        if (scan_clr) begin
            w_ch = '0;
        end else if (!mode) begin
            w_ch = sel;
        end else begin
            w_ch = w_scan_cnt;
        end
    end

    assign w_accept = in_valid && (!r_z_valid || out_ready);

    muxn_scan_cnt #(.N(N)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_accept && mode),
        .clr   (scan_clr),
        .cnt   (w_scan_cnt)
    );

    // Output stage: load on accept, drain on ready, otherwise hold (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z       <= '0;
            r_z_ch    <= '0;
            r_z_valid <= 1'b0;
        end else if (w_accept) begin
            r_z       <= w_chan[w_ch];
            r_z_ch    <= w_ch;
            r_z_valid <= 1'b1;
        end else if (out_ready) begin
            r_z       <= r_z;
            r_z_ch    <= r_z_ch;
            r_z_valid <= 1'b0;
        end else begin
            r_z       <= r_z;
            r_z_ch    <= r_z_ch;
            r_z_valid <= r_z_valid;
        end
    end

    assign z       = r_z;
    assign z_ch    = r_z_ch;
    assign z_valid = r_z_valid;

`ifdef SEL_ERR_EN
    // Only sel can reach an index >= N; the scan counter wraps at N-1 and
    // scan_clr forces channel 0.
    logic w_oor;
    logic r_sel_err;

    assign w_oor = (SLOTS != N) && (w_ch > SEL_W'(N - 1));

    // Error flag travels with the transfer and clears with z_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept) begin
            r_sel_err <= w_oor;
        end else if (out_ready) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= r_sel_err;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_muxn_scan.sv
// -----------------------------------------------------------------------------
// tb_muxn_scan
// Directed bench for muxn_scan with N = 7, WIDTH = 8. Channel k carries
// 8'h10 + k, so the expected z for channel k is simply 8'h10 + k.
// -----------------------------------------------------------------------------
module tb_muxn_scan;

    localparam int N     = 7;
    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               mode;
    logic [2:0]         sel;
    logic               scan_clr;
    logic [N*WIDTH-1:0] din;
    logic               out_ready;
    logic [WIDTH-1:0]   z;
    logic               z_valid;
    logic [2:0]         z_ch;
`ifdef SEL_ERR_EN
    logic               sel_err;
`endif

    int checks;
    int failures;

    muxn_scan #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .sel       (sel),
        .scan_clr  (scan_clr),
        .din       (din),
        .out_ready (out_ready),
        .z         (z),
        .z_valid   (z_valid),
`ifdef SEL_ERR_EN
        .sel_err   (sel_err),
`endif
        .z_ch      (z_ch)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_din(input logic [7:0] base);
        for (int k = 0; k < N; k++) begin
            din[k*WIDTH +: WIDTH] = base + 8'(k);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ez,
                           input logic [2:0] ech, input logic ev);
        chk({tag, ".z"},       32'(z),       32'(ez));
        chk({tag, ".z_ch"},    32'(z_ch),    32'(ech));
        chk({tag, ".z_valid"}, 32'(z_valid), 32'(ev));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        sel       = 3'd0;
        scan_clr  = 1'b0;
        out_ready = 1'b1;
        load_din(8'h10);

        // Reset state
        #12;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
`ifdef SEL_ERR_EN
        chk("reset.sel_err", 32'(sel_err), 32'd0);
`endif
        rst_n = 1'b1;
        #2;

        // External select, every channel, back-to-back
        in_valid = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = 3'(s);
            tick();
            chk_out($sformatf("sel%0d", s), 8'h10 + 8'(s), 3'(s), 1'b1);
        end

        // No accept with out_ready=1: valid drops, data/channel hold
        in_valid = 1'b0;
        tick();
        chk_out("drain", 8'h16, 3'd6, 1'b0);

        // Auto-scan: 9 transfers, wraps 6 -> 0 (counter untouched by mode 0)
        mode     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("scan%0d", i), 8'h10 + 8'(i % N), 3'(i % N), 1'b1);
        end

        // Back-pressure: 3 stalled cycles, din changes must not leak in
        out_ready = 1'b0;
        load_din(8'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("stall%0d", i), 8'h11, 3'd1, 1'b1);
        end
        load_din(8'h10);
        out_ready = 1'b1;
        tick();
        chk_out("resume", 8'h12, 3'd2, 1'b1);
        tick();
        chk_out("scan_ch3", 8'h13, 3'd3, 1'b1);

        // scan_clr with accept in mode 1 at count 4: channel 0 now, 1 next
        scan_clr = 1'b1;
        tick();
        chk_out("clr_m1", 8'h10, 3'd0, 1'b1);
        scan_clr = 1'b0;
        tick();
        chk_out("after_clr_m1", 8'h11, 3'd1, 1'b1);

        // scan_clr in mode 0 (sel ignored): next scan transfer is channel 0
        mode     = 1'b0;
        sel      = 3'd5;
        scan_clr = 1'b1;
        tick();
        chk_out("clr_m0", 8'h10, 3'd0, 1'b1);
        scan_clr = 1'b0;
        mode     = 1'b1;
        tick();
        chk_out("after_clr_m0", 8'h10, 3'd0, 1'b1);

        // Out-of-range select
        mode = 1'b0;
        sel  = 3'd7;
        tick();
        chk_out("oor", 8'h00, 3'd7, 1'b1);
`ifdef SEL_ERR_EN
        chk("oor.sel_err", 32'(sel_err), 32'd1);
`endif
        sel = 3'd3;
        tick();
        chk_out("in_range", 8'h13, 3'd3, 1'b1);
`ifdef SEL_ERR_EN
        chk("in_range.sel_err", 32'(sel_err), 32'd0);
`endif

        // Async reset mid-transfer, no clock edge in between
        sel = 3'd4;
        tick();
        chk_out("pre_rst", 8'h14, 3'd4, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        tick();
        chk("post_rst_idle.z_valid", 32'(z_valid), 32'd0);
        mode     = 1'b1;
        in_valid = 1'b1;
        tick();
        chk_out("post_rst_first", 8'h10, 3'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
